// File: rtl/gcn_sparse_aggregator_if.sv
// Bus bundle for gcn_sparse_aggregator: run control, COO edge fetch,
// FM_WM row fetch and per-node argmax results.
// master = the aggregator engine, slave = host / row source side.
interface gcn_sparse_aggregator_if #(
   parameter int unsigned NUM_NODES      = 6,
   parameter int unsigned NUM_CLASSES    = 3,
   parameter int unsigned DOT_PROD_WIDTH = 16,
   parameter int unsigned MAX_EDGES      = 16,
   parameter int unsigned NODE_BW        = $clog2(NUM_NODES),
   parameter int unsigned EDGE_BW        = $clog2(MAX_EDGES + 1),
   parameter int unsigned CLASS_BW       = $clog2(NUM_CLASSES)
);
   // run control
   logic                             start;
   logic [EDGE_BW-1:0]               num_edges;
   logic                             busy;
   logic                             done;
   logic                             overflow;
   // COO edge list fetch
   logic [EDGE_BW-1:0]               coo_address;
   logic [NODE_BW-1:0]               coo_src;
   logic [NODE_BW-1:0]               coo_dst;
   // FM_WM row fetch
   logic [NODE_BW-1:0]               fm_wm_row_addr;
   logic signed [DOT_PROD_WIDTH-1:0] fm_wm_row_data [NUM_CLASSES];
   // results
   logic [CLASS_BW-1:0]              max_addi_answer [0:NUM_NODES-1];

   modport master (
      input  start, num_edges, coo_src, coo_dst, fm_wm_row_data,
      output busy, done, overflow, coo_address, fm_wm_row_addr, max_addi_answer
   );

   modport slave (
      output start, num_edges, coo_src, coo_dst, fm_wm_row_data,
      input  busy, done, overflow, coo_address, fm_wm_row_addr, max_addi_answer
   );
endinterface

// File: rtl/gcn_sparse_aggregator.sv
// GCN sparse aggregation + per-node argmax classifier.
// Streams a COO edge list, accumulates (A + A^T)·FM_WM into saturating
// signed accumulators, then writes one argmax class per node.
// Optional macro GCN_SELF_LOOP_EN adds a self-loop pass, giving
// (A + A^T + I)·FM_WM.
module gcn_sparse_aggregator #(
   parameter int unsigned NUM_NODES      = 6,
   parameter int unsigned NUM_CLASSES    = 3,
   parameter int unsigned DOT_PROD_WIDTH = 16,
   parameter int unsigned ACC_WIDTH      = 20,
   parameter int unsigned MAX_EDGES      = 16,
   parameter int unsigned NODE_BW        = $clog2(NUM_NODES),
   parameter int unsigned EDGE_BW        = $clog2(MAX_EDGES + 1),
   parameter int unsigned CLASS_BW       = $clog2(NUM_CLASSES)
) (
   input logic                     clk,
   input logic                     reset,
   gcn_sparse_aggregator_if.master bus
);

   typedef enum logic [3:0] {
      IDLE,
`ifdef GCN_SELF_LOOP_EN
      SELF_ADDR,
      SELF_ACC,
`endif
      E_ADDR,
      E_LATCH,
      E_ACC_DST,
      E_ACC_SRC,
      ARGMAX,
      DONE
   } state_t;

   state_t                      state_q, state_d;
   logic [EDGE_BW-1:0]          e_q, e_d;
   logic [EDGE_BW-1:0]          edges_q, edges_d;
   logic [NODE_BW-1:0]          n_q, n_d;
   logic [NODE_BW-1:0]          src_q, src_d;
   logic [NODE_BW-1:0]          dst_q, dst_d;
   logic [EDGE_BW-1:0]          coo_address_q, coo_address_d;
   logic [NODE_BW-1:0]          row_addr_q, row_addr_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        overflow_q, overflow_d;
   logic signed [ACC_WIDTH-1:0] acc_q [NUM_NODES][NUM_CLASSES];
   logic signed [ACC_WIDTH-1:0] acc_d [NUM_NODES][NUM_CLASSES];
   logic [CLASS_BW-1:0]         answer_q [0:NUM_NODES-1];
   logic [CLASS_BW-1:0]         answer_d [0:NUM_NODES-1];

   // accumulate datapath
   logic                        acc_we;
   logic                        acc_idx_ok;
   logic [NODE_BW-1:0]          acc_idx;
   logic [ACC_WIDTH-1:0]        sel_acc [NUM_CLASSES];
   logic [ACC_WIDTH:0]          acc_sum [NUM_CLASSES];   // {saturated, value}

   // argmax datapath
   logic signed [ACC_WIDTH-1:0] am_row [NUM_CLASSES];
   logic signed [ACC_WIDTH-1:0] am_val;
   logic [CLASS_BW-1:0]         am_best;

   logic [EDGE_BW-1:0]          start_edges;
   logic [EDGE_BW-1:0]          e_inc;

   // Sign-extend d, add with one guard bit, clamp on overflow.
   // Returns {saturated, clamped_sum}.
   function automatic logic [ACC_WIDTH:0] sat_add(
      input logic [ACC_WIDTH-1:0]      a,
      input logic [DOT_PROD_WIDTH-1:0] d
   );
      logic [ACC_WIDTH:0] s;
      s = {a[ACC_WIDTH-1], a}
        + {{(ACC_WIDTH + 1 - DOT_PROD_WIDTH){d[DOT_PROD_WIDTH-1]}}, d};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
         return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
      end
      return {1'b0, s[ACC_WIDTH-1:0]};
   endfunction

   assign start_edges = (bus.num_edges > EDGE_BW'(MAX_EDGES)) ? EDGE_BW'(MAX_EDGES)
                                                              : bus.num_edges;
   assign e_inc       = e_q + EDGE_BW'(1);

   // Pick the accumulator row targeted this cycle and form its saturated sums
   always_comb begin
      acc_we  = 1'b0;
      acc_idx = n_q;
      unique case (state_q)
`ifdef GCN_SELF_LOOP_EN
         SELF_ACC: begin
            acc_we  = 1'b1;
            acc_idx = n_q;
         end
`endif
         E_ACC_DST: begin
            acc_we  = 1'b1;
            acc_idx = dst_q;
         end
         // a diagonal edge contributes only once
         E_ACC_SRC: begin
            acc_we  = (src_q != dst_q);
            acc_idx = src_q;
         end
         default: ;
      endcase
      // out-of-range node indices are dropped, never written
      acc_idx_ok = (32'(acc_idx) < NUM_NODES);

      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
         sel_acc[c] = '0;
      end
      for (int unsigned i = 0; i < NUM_NODES; i++) begin
         if (acc_idx == NODE_BW'(i)) begin
            for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
               sel_acc[c] = acc_q[i][c];
            end
         end
      end
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
         acc_sum[c] = sat_add(sel_acc[c], bus.fm_wm_row_data[c]);
      end
   end

   // Signed argmax of node n_q; strict compare keeps the lowest index on ties
   always_comb begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
         am_row[c] = '0;
      end
      for (int unsigned i = 0; i < NUM_NODES; i++) begin
         if (n_q == NODE_BW'(i)) begin
            for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
               am_row[c] = acc_q[i][c];
            end
         end
      end
      am_best = '0;
      am_val  = am_row[0];
      for (int unsigned c = 1; c < NUM_CLASSES; c++) begin
         if (am_row[c] > am_val) begin
            am_val  = am_row[c];
            am_best = CLASS_BW'(c);
         end
      end
   end

   // Next-state and next-output logic for the run sequencer
   always_comb begin
      state_d       = state_q;
      e_d           = e_q;
      edges_d       = edges_q;
      n_d           = n_q;
      src_d         = src_q;
      dst_d         = dst_q;
      coo_address_d = coo_address_q;
      row_addr_d    = row_addr_q;
      busy_d        = busy_q;
      done_d        = done_q;
      overflow_d    = overflow_q;
      acc_d         = acc_q;
      answer_d      = answer_q;

      if (acc_we && acc_idx_ok) begin
         for (int unsigned i = 0; i < NUM_NODES; i++) begin
            if (acc_idx == NODE_BW'(i)) begin
               for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                  acc_d[i][c] = acc_sum[c][ACC_WIDTH-1:0];
                  if (acc_sum[c][ACC_WIDTH]) begin
                     overflow_d = 1'b1;
                  end
               end
            end
         end
      end

      unique case (state_q)
         // DONE accepts a new start exactly like IDLE
         IDLE, DONE: begin
            if (bus.start) begin
               for (int unsigned i = 0; i < NUM_NODES; i++) begin
                  for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                     acc_d[i][c] = '0;
                  end
               end
               overflow_d = 1'b0;
               done_d     = 1'b0;
               busy_d     = 1'b1;
               e_d        = '0;
               n_d        = '0;
               edges_d    = start_edges;
`ifdef GCN_SELF_LOOP_EN
               state_d    = SELF_ADDR;
`else
               state_d    = (start_edges == '0) ? ARGMAX : E_ADDR;
`endif
            end
         end
`ifdef GCN_SELF_LOOP_EN
         SELF_ADDR: begin
            row_addr_d = n_q;
            state_d    = SELF_ACC;
         end
         SELF_ACC: begin
            if (n_q == NODE_BW'(NUM_NODES - 1)) begin
               n_d     = '0;
               state_d = (edges_q == '0) ? ARGMAX : E_ADDR;
            end else begin
               n_d     = n_q + NODE_BW'(1);
               state_d = SELF_ADDR;
            end
         end
`endif
         E_ADDR: begin
            coo_address_d = e_q;
            state_d       = E_LATCH;
         end
         // row data for acc[dst] is row[src], and vice versa one cycle later
         E_LATCH: begin
            src_d      = bus.coo_src;
            dst_d      = bus.coo_dst;
            row_addr_d = bus.coo_src;
            state_d    = E_ACC_DST;
         end
         E_ACC_DST: begin
            row_addr_d = dst_q;
            state_d    = E_ACC_SRC;
         end
         E_ACC_SRC: begin
            e_d = e_inc;
            if (e_inc == edges_q) begin
               n_d     = '0;
               state_d = ARGMAX;
            end else begin
               state_d = E_ADDR;
            end
         end
         ARGMAX: begin
            for (int unsigned i = 0; i < NUM_NODES; i++) begin
               if (n_q == NODE_BW'(i)) begin
                  answer_d[i] = am_best;
               end
            end
            if (n_q == NODE_BW'(NUM_NODES - 1)) begin
               n_d     = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end else begin
               n_d = n_q + NODE_BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, accumulators and registered outputs; async active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         e_q           <= '0;
         edges_q       <= '0;
         n_q           <= '0;
         src_q         <= '0;
         dst_q         <= '0;
         coo_address_q <= '0;
         row_addr_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         overflow_q    <= 1'b0;
         for (int unsigned i = 0; i < NUM_NODES; i++) begin
            answer_q[i] <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
               acc_q[i][c] <= '0;
            end
         end
      end else begin
         state_q       <= state_d;
         e_q           <= e_d;
         edges_q       <= edges_d;
         n_q           <= n_d;
         src_q         <= src_d;
         dst_q         <= dst_d;
         coo_address_q <= coo_address_d;
         row_addr_q    <= row_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         overflow_q    <= overflow_d;
         acc_q         <= acc_d;
         answer_q      <= answer_d;
      end
   end

   assign bus.coo_address     = coo_address_q;
   assign bus.fm_wm_row_addr  = row_addr_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.overflow        = overflow_q;
   assign bus.max_addi_answer = answer_q;

endmodule
